// File: rtl/two_parallel_pkg.sv
// two_parallel_pkg: shared types and the shift/narrow helper for the two-parallel serializer.
// Build option: SERIALIZER_SAT_EN makes sat_narrow clamp to the output range and report clipping;
// without it sat_narrow only shifts and the caller wraps by truncation.
package two_parallel_pkg;
    localparam int PAIR_W = 64;
    typedef logic signed [PAIR_W-1:0] sample64_t;
    typedef struct packed {
        sample64_t s1;
        sample64_t s2;
    } pair_t;
    typedef struct packed {
        sample64_t val;
        logic      clip;
    } narrow_t;
    typedef enum logic {LANE1 = 1'b0, LANE2 = 1'b1} phase_t;
    function automatic narrow_t sat_narrow(input sample64_t value, input int out_w, input int shift);
        narrow_t r;
        sample64_t s;
`ifdef SERIALIZER_SAT_EN
        sample64_t hi;
        sample64_t lo;
`endif
        s = value >>> shift;
        r.val  = s;
        r.clip = 1'b0;
`ifdef SERIALIZER_SAT_EN
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (s < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
`else
        if (out_w < 0) r.clip = 1'b0;
`endif
        return r;
    endfunction
endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: register-based FIFO of sample pairs.
// Ports: clk, rst_n (async active-low), push/din write side, pop/head read side,
// level = number of stored pairs. Pointers wrap modulo DEPTH (power of two).
module pair_fifo
    import two_parallel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  pair_t                      din,
    input  logic                       pop,
    output pair_t                      head,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    pair_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop) r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(push) - LW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= din;
    end
    assign head  = r_mem[r_rptr];
    assign level = r_level;
endmodule

// File: rtl/two_parallel_serializer.sv
// two_parallel_serializer: buffers 64-bit FIR result pairs and emits them one sample per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/din1/din2 pair input;
// out_valid/out_ready/dout sample output; sat_flag sticky clip indicator; level = stored pairs.
// Build option: SERIALIZER_SAT_EN selects clamping (sat_flag live) instead of two's-complement wrap.
module two_parallel_serializer
    import two_parallel_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [63:0]       din1,
    input  logic signed [63:0]       din2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     sat_flag,
    output logic [$clog2(DEPTH):0]   level
);
    phase_t                   r_phase;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_dout;
    logic [$clog2(DEPTH):0]   w_level;
    pair_t                    w_head;
    pair_t                    w_in_pair;
    logic                     w_push;
    logic                     w_slot;
    logic                     w_load;
    logic                     w_pop;
    narrow_t                  w_nar;
    logic                     w_unused;
    // in_ready depends on level only, so a pop never frees a slot in the same cycle
    assign in_ready  = w_level != DEPTH[$clog2(DEPTH):0];
    assign w_push    = in_valid && in_ready;
    assign w_in_pair = '{s1: din1, s2: din2};
    assign w_slot    = !r_out_valid || out_ready;
    assign w_load    = w_slot && w_level != '0;
    assign w_pop     = w_load && r_phase == LANE2;
    assign w_nar     = sat_narrow(r_phase == LANE1 ? w_head.s1 : w_head.s2, OUT_W, SHIFT);
    assign w_unused  = ^{w_nar.val[63:OUT_W], w_nar.clip};
    pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_in_pair),
        .pop   (w_pop),
        .head  (w_head),
        .level (w_level)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= LANE1;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
        end else if (w_load) begin
            r_phase     <= r_phase == LANE1 ? LANE2 : LANE1;
            r_out_valid <= 1'b1;
            r_dout      <= w_nar.val[OUT_W-1:0];
        end else if (w_slot) begin
            r_out_valid <= 1'b0;
        end
    end
`ifdef SERIALIZER_SAT_EN
    logic r_sat;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sat <= 1'b0;
        else if (w_load && w_nar.clip) r_sat <= 1'b1;
    end
    assign sat_flag = r_sat;
`else
    assign sat_flag = 1'b0;
`endif
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign level     = w_level;
endmodule

// File: tb/tb_two_parallel_serializer.sv
// tb_two_parallel_serializer: directed self-checking bench for two_parallel_serializer.
module tb_two_parallel_serializer;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [63:0] din1 = '0;
    logic signed [63:0] din2 = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] dout;
    logic               sat_flag;
    logic [2:0]         level;
    logic               s_in_valid = 1'b0;
    logic               s_in_ready;
    logic signed [63:0] s_din1 = '0;
    logic signed [63:0] s_din2 = '0;
    logic               s_out_valid;
    logic signed [15:0] s_dout;
    logic               s_sat_flag;
    logic [2:0]         s_level;
    int                 n_chk = 0;
    int                 n_pass = 0;
    longint             got_q[$];
    longint             exp_q[$];
    logic               prev_stall = 1'b0;
    logic signed [15:0] prev_dout = '0;

    always #5 clk = ~clk;

    two_parallel_serializer #(.DEPTH(4), .OUT_W(16), .SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din1(din1), .din2(din2), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .sat_flag(sat_flag), .level(level)
    );

    two_parallel_serializer #(.DEPTH(4), .OUT_W(16), .SHIFT(4)) u_dut_sh (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din1(s_din1), .din2(s_din2), .out_valid(s_out_valid), .out_ready(1'b1),
        .dout(s_dout), .sat_flag(s_sat_flag), .level(s_level)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, longint'(got_q.size()), longint'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, i < got_q.size() ? got_q[i] : -64'sd999999, exp_q[i]);
    endtask

    // collect accepted samples and verify the output holds while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_dout", dout, prev_dout);
            end
            if (out_valid && out_ready) got_q.push_back(dout);
            prev_stall = out_valid && !out_ready;
            prev_dout = dout;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_dout", dout, 0);
        check("rst_sat", longint'(sat_flag), 0);
        check("rst_level", longint'(level), 0);
        check("rst_in_ready", longint'(in_ready), 1);

        // single pair, plus the SHIFT=4 instance in parallel
        din1 = 5; din2 = -7; in_valid = 1'b1;
        s_din1 = 64'sh100; s_din2 = -64'sh100; s_in_valid = 1'b1;
        tick();
        in_valid = 1'b0; s_in_valid = 1'b0;
        check("single_level", longint'(level), 1);
        check("single_nolat", longint'(out_valid), 0);
        tick();
        check("single_lane1", dout, 5);
        check("single_v1", longint'(out_valid), 1);
        check("shift_lane1", s_dout, 16);
        tick();
        check("single_lane2", dout, -7);
        check("shift_lane2", s_dout, -16);
        check("single_level0", longint'(level), 0);
        tick();
        check("single_bubble", longint'(out_valid), 0);
        check("shift_bubble", longint'(s_out_valid), 0);
        check("shift_sat", longint'(s_sat_flag), 0);

        // ordering under toggling backpressure
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            din1 = 2 * i + 1; din2 = 2 * i + 2; in_valid = 1'b1;
            out_ready = ~out_ready;
            check("bp_in_ready", longint'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (16) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        tick();
        exp_q.delete();
        for (int i = 1; i <= 6; i++) exp_q.push_back(i);
        check_seq("bp_seq");

        // fill the FIFO while stalled
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din1 = 10 + 2 * i; din2 = 11 + 2 * i; in_valid = 1'b1;
            check("full_accept", longint'(in_ready), 1);
            tick();
        end
        din1 = 18; din2 = 19;
        check("full_level", longint'(level), 4);
        check("full_in_ready", longint'(in_ready), 0);
        tick();
        check("full_held", longint'(level), 4);
        out_ready = 1'b1;
        check("full_no_pass", longint'(in_ready), 0);
        begin
            int k = 0;
            while (!in_ready && k < 10) begin
                tick();
                k++;
            end
        end
        check("full_reopen", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        run(16);
        exp_q.delete();
        for (int i = 10; i <= 19; i++) exp_q.push_back(i);
        check_seq("full_seq");

        // out-of-range samples
        got_q.delete();
        din1 = 40000; din2 = -40000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run(5);
        exp_q.delete();
`ifdef SERIALIZER_SAT_EN
        exp_q.push_back(32767);
        exp_q.push_back(-32768);
        check_seq("sat_seq");
        check("sat_flag", longint'(sat_flag), 1);
`else
        exp_q.push_back(-25536);
        exp_q.push_back(25536);
        check_seq("wrap_seq");
        check("wrap_flag", longint'(sat_flag), 0);
`endif

        // reset after lane 1 of a pair has been emitted
        din1 = 9; din2 = 10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_lane1", dout, 9);
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", longint'(out_valid), 0);
        check("mid_async_level", longint'(level), 0);
        run(2);
        rst_n = 1'b1;
        tick();
        check("mid_level", longint'(level), 0);
        check("mid_valid", longint'(out_valid), 0);
        check("mid_sat", longint'(sat_flag), 0);
        check("mid_in_ready", longint'(in_ready), 1);
        got_q.delete();
        run(6);
        check("mid_no_lane2", longint'(got_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/two_parallel_serializer.md
# two_parallel_serializer

- Output end of the two-parallel FIR datapath.
- Accepts one pair of 64-bit filter results per handshake: lane 1 is the earlier sample, lane 2 the later one.
- Scales and narrows each result, then emits the samples one per cycle, in time order, on a single valid/ready stream.
- Buffers pairs in a small FIFO so the downstream consumer can stall without losing filter output.

## Interface

Parameters:
- DEPTH, 4 — FIFO capacity in pairs; power of two, ≥2.
- OUT_W, 16 — output sample width.
- SHIFT, 0 — arithmetic right shift applied before narrowing, range 0..47.

Ports:
- clk  in  1  — single clock; all logic on the rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — pair present on din1/din2.
- in_ready  out  1  — pair will be accepted this cycle.
- din1  in  64 signed  — earlier sample of the pair.
- din2  in  64 signed  — later sample of the pair.
- out_valid  out  1  — dout holds a sample.
- out_ready  in  1  — downstream accepts dout.
- dout  out  OUT_W signed  — serialized sample.
- sat_flag  out  1  — sticky: some sample has been clipped.
- level  out  clog2(DEPTH)+1  — pairs currently stored in the FIFO.

## Operation

Input side:
- Push when in_valid && in_ready; in_ready = (level != DEPTH).
- No pass-through when full: a pop and a push-attempt in the same cycle while full still sees in_ready=0.
- Push and pop in the same cycle when not full: level is unchanged.
- Write and read pointers wrap modulo DEPTH.

Read side:
- A 1-bit phase selects the lane of the FIFO head: phase 0 = din1, phase 1 = din2.

Output register:
- Loads when (!out_valid || out_ready) && level != 0.
- Each load advances phase.
- The load that consumes lane 2 also pops the head and returns phase to 0.
- If the condition holds with level == 0, out_valid falls to 0 (at most one bubble).

Arithmetic, per sample:
- Compute s = x >>> SHIFT (sign-preserving, no rounding).
- Narrow to OUT_W per the configuration below.
- Narrowing is applied on the load path, not at FIFO write; the FIFO stores raw 64-bit values.

State: phase has two states, LANE1 and LANE2.
- LANE1 → LANE2 on a load.
- LANE2 → LANE1 on a load, with pop.
- No transition without a load.

Reset (asynchronous assertion, deassertion sampled on the next edge):
- level = 0, pointers = 0, phase = LANE1.
- out_valid = 0, dout = 0, sat_flag = 0, in_ready = 1 one cycle after deassertion.
- Reset mid-stream discards all stored pairs, including a half-emitted pair.

## Timing

- Latency: a pair pushed at edge N gives lane 1 on dout after edge N+1 (empty FIFO, out_ready=1), and lane 2 after edge N+2.
- Throughput: one output sample per cycle, i.e. one pair per two cycles sustained. in_ready deasserts once the FIFO fills under a one-pair-per-cycle input.
- dout and out_valid are registered. in_ready is a function of level only, with no combinational path from out_ready.
- dout holds stable while out_valid && !out_ready.

## Configuration

Macro: SERIALIZER_SAT_EN.

Defined:
- s above 2^(OUT_W-1)-1 clamps to that value.
- s below -2^(OUT_W-1) clamps to that value.
- sat_flag sets on any clamping load and stays set until reset.

Undefined:
- dout = s[OUT_W-1:0] (two's-complement wrap).
- sat_flag is tied to 0.

## Structure

- Package two_parallel_pkg holds:
  - PAIR_W = 64
  - typedef sample64_t (logic signed [63:0])
  - typedef pair_t (struct of two sample64_t)
  - function sat_narrow(value, OUT_W, SHIFT) returning the narrowed value and a clip bit
- Sub-module pair_fifo: DEPTH-entry pair_t storage with push/pop/level. Implemented in registers; no RAM inference.
- Top level holds phase, the output register, the narrowing path and sat_flag.

## Test plan

- Single pair: reset, push din1=5, din2=-7 with out_ready=1 → dout=5 after edge 2, dout=-7 after edge 3, then out_valid=0.
- Ordering under backpressure: push pairs (1,2), (3,4), (5,6) with out_ready toggling every cycle → dout sequence is 1,2,3,4,5,6 with no loss or duplication. dout stays stable while stalled.
- Full FIFO: out_ready=0, offer 5 pairs with DEPTH=4 → in_ready drops after 4 pushes, level=4, the 5th pair is held off. Raise out_ready → 8 samples in order, then the 5th pair's samples.
- Saturation (SERIALIZER_SAT_EN, OUT_W=16, SHIFT=0): push (40000, -40000) → dout 32767 then -32768, sat_flag=1. Without the macro → dout -25536 then 25536, sat_flag=0.
- Shift: SHIFT=4, push (0x100, -0x100) → dout 16 then -16.
- Reset mid-pair: push (9,10), assert rst_n=0 right after lane 1 is emitted → after release no 10 appears; level=0, out_valid=0, sat_flag=0.
